// File: rtl/alu_rs_pkg.sv
// ---------------------------------------------------------------------------
// alu_rs_pkg
// Shared widths, ALU opcode encoding and entry/operand types for the ALU
// reservation station slice. XLEN, ALU_OP_WIDTH and ROB_SIZE_WIDTH mirror the
// core-wide widths; RS_SIZE_WIDTH / RS_SIZE size the station (8 entries).
// Also hosts resolve_operand(), the single operand-capture rule shared by
// issue (dec_* operand) and wakeup (stored operand).
// ---------------------------------------------------------------------------
package alu_rs_pkg;

  localparam int XLEN           = 32;
  localparam int ALU_OP_WIDTH   = 4;
  localparam int ROB_SIZE_WIDTH = 4;
  localparam int RS_SIZE_WIDTH  = 3;
  localparam int RS_SIZE        = 1 << RS_SIZE_WIDTH;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2,  ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,  ALU_SLL  = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,  ALU_SLTU = 4'd9,  ALU_BEQ  = 4'd10, ALU_BNE  = 4'd11,
    ALU_BLT  = 4'd12, ALU_BGE  = 4'd13, ALU_BLTU = 4'd14, ALU_BGEU = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic                      busy;
    logic [ALU_OP_WIDTH-1:0]   op;
    logic [XLEN-1:0]           v1;
    logic [XLEN-1:0]           v2;
    logic                      w1;   // operand 1 still waiting on q1
    logic                      w2;   // operand 2 still waiting on q2
    logic [ROB_SIZE_WIDTH-1:0] q1;
    logic [ROB_SIZE_WIDTH-1:0] q2;
    logic [ROB_SIZE_WIDTH-1:0] id;
  } rs_entry_t;

  typedef struct packed {
    logic [XLEN-1:0] val;
    logic            pend;   // still waiting after this cycle
  } opnd_t;

  // Operand capture: already-available values pass through; otherwise a
  // matching broadcast supplies the value, ALU result taking priority.
  function automatic opnd_t resolve_operand(
    input logic                      has,
    input logic [XLEN-1:0]           cur_val,
    input logic [ROB_SIZE_WIDTH-1:0] tag,
    input logic                      alu_ready,
    input logic [XLEN-1:0]           alu_res,
    input logic [ROB_SIZE_WIDTH-1:0] alu_id,
    input logic                      lsb_ready,
    input logic [XLEN-1:0]           lsb_res,
    input logic [ROB_SIZE_WIDTH-1:0] lsb_id
  );
    opnd_t r;
    if (has) begin
      r = '{val: cur_val, pend: 1'b0};
    end else if (alu_ready && alu_id == tag) begin
      r = '{val: alu_res, pend: 1'b0};
    end else if (lsb_ready && lsb_id == tag) begin
      r = '{val: lsb_res, pend: 1'b0};
    end else begin
      r = '{val: cur_val, pend: 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_select.sv
// ---------------------------------------------------------------------------
// rs_select
// Combinational one-of-N picker used for both dispatch selection and
// free-slot search.
//   older  in  N x N  (only with RS_OLDEST_FIRST_EN) older[i][j]=1: j older than i
//   cand   in  N      candidate vector
//   found  out 1      at least one eligible candidate
//   idx    out W      index of the chosen candidate
// An entry is eligible when it is a candidate and no other candidate is older
// than it. With an all-zero age matrix (or RS_OLDEST_FIRST_EN undefined)
// every candidate is eligible, so the lowest-index candidate is chosen.
// ---------------------------------------------------------------------------
module rs_select
  import alu_rs_pkg::*;
#(
  parameter int N = RS_SIZE,
  parameter int W = RS_SIZE_WIDTH
) (
`ifdef RS_OLDEST_FIRST_EN
  input  logic [N-1:0][N-1:0] older,
`endif
  input  logic [N-1:0]        cand,
  output logic                found,
  output logic [W-1:0]        idx
);

  logic [N-1:0] elig;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_elig
`ifdef RS_OLDEST_FIRST_EN
      assign elig[gi] = cand[gi] && ((older[gi] & cand) == '0);
`else
      assign elig[gi] = cand[gi];
`endif
    end
  endgenerate

  // Scan downward so the lowest eligible index is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ---------------------------------------------------------------------------
// alu_rs
// Reservation station for integer/branch ops. Holds issued ops until both
// operands are valid, snoops the ALU and LSB result broadcasts, and dispatches
// at most one ready op per cycle to the ALU as a registered one-cycle pulse.
// Ports:
//   clk, rst (sync, active-high), rdy (low freezes everything), flush
//   dec_valid/op/val1/val2/has1/has2/q1/q2/id   issue from decoder
//   rs_full                                     all entries busy (comb)
//   alu_ready/res/id, lsb_ready/res/id           result broadcasts
//   rs_ready/op/val1/val2/id                     dispatch to ALU
// Option RS_OLDEST_FIRST_EN: keep an age matrix and dispatch the oldest ready
// entry; otherwise the lowest-index ready entry is dispatched.
// ---------------------------------------------------------------------------
module alu_rs
  import alu_rs_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      dec_valid,
  input  logic [ALU_OP_WIDTH-1:0]   dec_op,
  input  logic [XLEN-1:0]           dec_val1,
  input  logic [XLEN-1:0]           dec_val2,
  input  logic                      dec_has1,
  input  logic                      dec_has2,
  input  logic [ROB_SIZE_WIDTH-1:0] dec_q1,
  input  logic [ROB_SIZE_WIDTH-1:0] dec_q2,
  input  logic [ROB_SIZE_WIDTH-1:0] dec_id,
  output logic                      rs_full,
  input  logic                      alu_ready,
  input  logic [XLEN-1:0]           alu_res,
  input  logic [ROB_SIZE_WIDTH-1:0] alu_id,
  input  logic                      lsb_ready,
  input  logic [XLEN-1:0]           lsb_res,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_id,
  output logic                      rs_ready,
  output logic [ALU_OP_WIDTH-1:0]   rs_op,
  output logic [XLEN-1:0]           rs_val1,
  output logic [XLEN-1:0]           rs_val2,
  output logic [ROB_SIZE_WIDTH-1:0] rs_id
);

  rs_entry_t ent_reg [RS_SIZE];

  logic                      rs_ready_reg;
  logic [ALU_OP_WIDTH-1:0]   rs_op_reg;
  logic [XLEN-1:0]           rs_val1_reg;
  logic [XLEN-1:0]           rs_val2_reg;
  logic [ROB_SIZE_WIDTH-1:0] rs_id_reg;

`ifdef RS_OLDEST_FIRST_EN
  logic [RS_SIZE-1:0][RS_SIZE-1:0] older_reg;
`endif

  logic [RS_SIZE-1:0]       busy_vec;
  logic [RS_SIZE-1:0]       cand_vec;
  opnd_t                    wake1 [RS_SIZE];
  opnd_t                    wake2 [RS_SIZE];
  opnd_t                    iss1;
  opnd_t                    iss2;
  logic                     sel_found;
  logic [RS_SIZE_WIDTH-1:0] sel_idx;
  logic                     free_found;
  logic [RS_SIZE_WIDTH-1:0] free_idx;
  logic                     issue_en;

  // Per-entry views of registered state: busy, dispatch candidacy (state at
  // clock start, so a same-cycle wakeup only dispatches next cycle) and the
  // operand values after this cycle's broadcast snoop.
  genvar gi;
  generate
    for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
      assign busy_vec[gi] = ent_reg[gi].busy;
      assign cand_vec[gi] = ent_reg[gi].busy && !ent_reg[gi].w1 && !ent_reg[gi].w2;
      assign wake1[gi] = resolve_operand(!ent_reg[gi].w1, ent_reg[gi].v1, ent_reg[gi].q1,
                                         alu_ready, alu_res, alu_id,
                                         lsb_ready, lsb_res, lsb_id);
      assign wake2[gi] = resolve_operand(!ent_reg[gi].w2, ent_reg[gi].v2, ent_reg[gi].q2,
                                         alu_ready, alu_res, alu_id,
                                         lsb_ready, lsb_res, lsb_id);
    end
  endgenerate

  assign iss1 = resolve_operand(dec_has1, dec_val1, dec_q1, alu_ready, alu_res, alu_id,
                                lsb_ready, lsb_res, lsb_id);
  assign iss2 = resolve_operand(dec_has2, dec_val2, dec_q2, alu_ready, alu_res, alu_id,
                                lsb_ready, lsb_res, lsb_id);

  // Full is taken from the pre-edge busy vector: a slot freed by this cycle's
  // dispatch cannot be refilled until the next cycle.
  assign rs_full = &busy_vec;

  rs_select u_pick (
`ifdef RS_OLDEST_FIRST_EN
    .older (older_reg),
`endif
    .cand  (cand_vec),
    .found (sel_found),
    .idx   (sel_idx)
  );

  rs_select u_free (
`ifdef RS_OLDEST_FIRST_EN
    .older ('0),
`endif
    .cand  (~busy_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  // free_found is exactly !rs_full; an issue while full is dropped.
  assign issue_en = dec_valid && free_found;

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        for (int i = 0; i < RS_SIZE; i++) ent_reg[i].busy <= 1'b0;
        rs_ready_reg <= 1'b0;
        rs_op_reg    <= '0;
        rs_val1_reg  <= '0;
        rs_val2_reg  <= '0;
        rs_id_reg    <= '0;
`ifdef RS_OLDEST_FIRST_EN
        older_reg    <= '0;
`endif
      end else if (flush) begin
        for (int i = 0; i < RS_SIZE; i++) ent_reg[i].busy <= 1'b0;
        rs_ready_reg <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ent_reg[i].busy) begin
            ent_reg[i].v1 <= wake1[i].val;
            ent_reg[i].w1 <= wake1[i].pend;
            ent_reg[i].v2 <= wake2[i].val;
            ent_reg[i].w2 <= wake2[i].pend;
          end
        end

        if (sel_found) begin
          rs_ready_reg           <= 1'b1;
          rs_op_reg              <= ent_reg[sel_idx].op;
          rs_val1_reg            <= ent_reg[sel_idx].v1;
          rs_val2_reg            <= ent_reg[sel_idx].v2;
          rs_id_reg              <= ent_reg[sel_idx].id;
          ent_reg[sel_idx].busy  <= 1'b0;
        end else begin
          rs_ready_reg <= 1'b0;
        end

        // Issue slot is free, dispatch slot is busy: the two never collide.
        if (issue_en) begin
          ent_reg[free_idx] <= '{busy: 1'b1, op: dec_op,
                                 v1: iss1.val, v2: iss2.val,
                                 w1: iss1.pend, w2: iss2.pend,
                                 q1: dec_q1, q2: dec_q2, id: dec_id};
`ifdef RS_OLDEST_FIRST_EN
          // Everything currently busy is older than the new op; stale bits
          // in the new op's column from its slot's previous life are cleared.
          older_reg[free_idx] <= busy_vec;
          for (int i = 0; i < RS_SIZE; i++) older_reg[i][free_idx] <= 1'b0;
`endif
        end
      end
    end
  end

  assign rs_ready = rs_ready_reg;
  assign rs_op    = rs_op_reg;
  assign rs_val1  = rs_val1_reg;
  assign rs_val2  = rs_val2_reg;
  assign rs_id    = rs_id_reg;

endmodule

// File: tb/tb_alu_rs.sv
// ---------------------------------------------------------------------------
// tb_alu_rs
// Self-checking bench for alu_rs: directed scenarios followed by randomized
// traffic, all outputs compared every cycle against a behavioural model that
// keeps entries with an issue sequence number for age.
// ---------------------------------------------------------------------------
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst, rdy, flush, dec_valid;
  logic [ALU_OP_WIDTH-1:0]   dec_op;
  logic [XLEN-1:0]           dec_val1, dec_val2;
  logic                      dec_has1, dec_has2;
  logic [ROB_SIZE_WIDTH-1:0] dec_q1, dec_q2, dec_id;
  logic                      rs_full;
  logic                      alu_ready, lsb_ready;
  logic [XLEN-1:0]           alu_res, lsb_res;
  logic [ROB_SIZE_WIDTH-1:0] alu_id, lsb_id;
  logic                      rs_ready;
  logic [ALU_OP_WIDTH-1:0]   rs_op;
  logic [XLEN-1:0]           rs_val1, rs_val2;
  logic [ROB_SIZE_WIDTH-1:0] rs_id;

  alu_rs dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .dec_valid(dec_valid), .dec_op(dec_op), .dec_val1(dec_val1), .dec_val2(dec_val2),
    .dec_has1(dec_has1), .dec_has2(dec_has2), .dec_q1(dec_q1), .dec_q2(dec_q2),
    .dec_id(dec_id), .rs_full(rs_full),
    .alu_ready(alu_ready), .alu_res(alu_res), .alu_id(alu_id),
    .lsb_ready(lsb_ready), .lsb_res(lsb_res), .lsb_id(lsb_id),
    .rs_ready(rs_ready), .rs_op(rs_op), .rs_val1(rs_val1), .rs_val2(rs_val2), .rs_id(rs_id)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          busy;
    logic [3:0]  op;
    logic [31:0] v1, v2;
    bit          w1, w2;
    logic [3:0]  q1, q2, id;
    int          age;
  } ment_t;

  ment_t       m [8];
  bit          m_ready;
  logic [3:0]  m_op, m_id;
  logic [31:0] m_v1, m_v2;
  int          age_ctr = 0;

  function automatic bit m_full();
    for (int i = 0; i < 8; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void snoop(input logic [3:0] q, inout bit w, inout logic [31:0] v);
    if (w) begin
      if (alu_ready && alu_id == q) begin v = alu_res; w = 1'b0; end
      else if (lsb_ready && lsb_id == q) begin v = lsb_res; w = 1'b0; end
    end
  endfunction

  task automatic model_edge();
    ment_t nm [8];
    int sel, fr;
    if (!rdy) return;
    if (rst || flush) begin
      for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
      m_ready = 1'b0;
      if (rst) begin m_op = 0; m_v1 = 0; m_v2 = 0; m_id = 0; end
      return;
    end
    nm = m;
    sel = -1;
    for (int i = 0; i < 8; i++) begin
      if (m[i].busy && !m[i].w1 && !m[i].w2) begin
`ifdef RS_OLDEST_FIRST_EN
        if (sel < 0 || m[i].age < m[sel].age) sel = i;
`else
        if (sel < 0) sel = i;
`endif
      end
    end
    m_ready = (sel >= 0);
    if (sel >= 0) begin
      m_op = m[sel].op; m_v1 = m[sel].v1; m_v2 = m[sel].v2; m_id = m[sel].id;
      nm[sel].busy = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      if (m[i].busy) begin
        snoop(m[i].q1, nm[i].w1, nm[i].v1);
        snoop(m[i].q2, nm[i].w2, nm[i].v2);
      end
    end
    if (dec_valid && !m_full()) begin
      fr = 0;
      while (m[fr].busy) fr++;
      nm[fr].busy = 1'b1; nm[fr].op = dec_op; nm[fr].id = dec_id;
      nm[fr].q1 = dec_q1; nm[fr].q2 = dec_q2;
      nm[fr].v1 = dec_val1; nm[fr].w1 = !dec_has1;
      nm[fr].v2 = dec_val2; nm[fr].w2 = !dec_has2;
      snoop(dec_q1, nm[fr].w1, nm[fr].v1);
      snoop(dec_q2, nm[fr].w2, nm[fr].v2);
      nm[fr].age = age_ctr++;
    end
    m = nm;
  endtask

  // Protocol guard: issuing into a full station is a driver error.
  always @(posedge clk)
    if (rdy && !rst && !flush && dec_valid && rs_full)
      $error("protocol violation: dec_valid while rs_full");

  // One clock: model advances on the same edge, outputs sampled 1ns later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("rs_ready", rs_ready, m_ready);
    chk("rs_full",  rs_full,  m_full());
    chk("rs_op",    rs_op,    m_op);
    chk("rs_val1",  rs_val1,  m_v1);
    chk("rs_val2",  rs_val2,  m_v2);
    chk("rs_id",    rs_id,    m_id);
  endtask

  task automatic iss(input logic [3:0] op, input logic h1, input logic [31:0] a, input logic [3:0] q1,
                     input logic h2, input logic [31:0] b, input logic [3:0] q2, input logic [3:0] id);
    dec_valid = 1'b1; dec_op = op; dec_has1 = h1; dec_val1 = a; dec_q1 = q1;
    dec_has2 = h2; dec_val2 = b; dec_q2 = q2; dec_id = id;
    cycle();
    dec_valid = 1'b0;
  endtask

  task automatic bcast_alu(input logic [3:0] id, input logic [31:0] res);
    alu_ready = 1'b1; alu_id = id; alu_res = res;
    cycle();
    alu_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; dec_valid = 1'b0;
    dec_op = 0; dec_val1 = 0; dec_val2 = 0; dec_has1 = 0; dec_has2 = 0;
    dec_q1 = 0; dec_q2 = 0; dec_id = 0;
    alu_ready = 0; alu_res = 0; alu_id = 0; lsb_ready = 0; lsb_res = 0; lsb_id = 0;
    for (int i = 0; i < 8; i++) m[i] = '{busy: 0, op: 0, v1: 0, v2: 0, w1: 0, w2: 0, q1: 0, q2: 0, id: 0, age: 0};
    m_ready = 0; m_op = 0; m_v1 = 0; m_v2 = 0; m_id = 0;
    cycle(); cycle();
    rst = 1'b0;
    chk("rst_ready", rs_ready, 0);
    chk("rst_full",  rs_full,  0);
    chk("rst_id",    rs_id,    0);

    // ADD both ready: pulse two edges after issue, exactly one cycle.
    iss(ALU_ADD, 1, 5, 0, 1, 7, 0, 3);
    chk("t1_early", rs_ready, 0);
    cycle();
    chk("t1_ready", rs_ready, 1);
    chk("t1_op",    rs_op,    ALU_ADD);
    chk("t1_val1",  rs_val1,  5);
    chk("t1_val2",  rs_val2,  7);
    chk("t1_id",    rs_id,    3);
    cycle();
    chk("t1_pulse", rs_ready, 0);

    // SUB waiting on ROB 4, woken by ALU broadcast.
    iss(ALU_SUB, 0, 0, 4, 1, 3, 0, 1);
    cycle(); cycle();
    bcast_alu(4, 32'h10);
    chk("t2_wait", rs_ready, 0);
    cycle();
    chk("t2_ready", rs_ready, 1);
    chk("t2_val1",  rs_val1,  32'h10);
    cycle();

    // Operand captured from LSB broadcast on the issue cycle.
    lsb_ready = 1'b1; lsb_id = 6; lsb_res = 9;
    iss(ALU_OR, 1, 2, 0, 0, 0, 6, 7);
    lsb_ready = 1'b0;
    cycle();
    chk("t3_ready", rs_ready, 1);
    chk("t3_val2",  rs_val2,  9);
    cycle();

    // Fill all eight entries waiting on tags 8..15.
    for (int i = 0; i < 8; i++) iss(ALU_ADD, 0, 0, 4'(8 + i), 1, i, 0, 4'(i));
    chk("t4_full", rs_full, 1);
    bcast_alu(13, 32'h55);
    chk("t4_still_full", rs_full, 1);
    cycle();
    chk("t4_ready", rs_ready, 1);
    chk("t4_id",    rs_id,    5);
    chk("t4_freed", rs_full,  0);
    iss(ALU_XOR, 0, 0, 3, 1, 1, 0, 9);
    chk("t4_refull", rs_full, 1);
    alu_ready = 1'b1; alu_id = 12; alu_res = 1;
    lsb_ready = 1'b1; lsb_id = 3;  lsb_res = 2;
    cycle();
    alu_ready = 1'b0; lsb_ready = 1'b0;
    cycle();
    chk("t4_first_id", rs_id, 4);
    cycle();
    chk("t4_refill_id", rs_id, 9);
    flush = 1'b1; cycle(); flush = 1'b0;
    chk("t4_flush_full", rs_full, 0);

    // Flush with four busy entries and a dispatch pending.
    iss(ALU_AND, 0, 0, 1, 1, 0, 0, 10);
    iss(ALU_AND, 0, 0, 2, 1, 0, 0, 11);
    iss(ALU_AND, 0, 0, 3, 1, 0, 0, 12);
    iss(ALU_AND, 1, 1, 0, 1, 1, 0, 13);
    flush = 1'b1; cycle(); flush = 1'b0;
    chk("t5_ready", rs_ready, 0);
    chk("t5_full",  rs_full,  0);
    for (int t = 1; t <= 3; t++) begin
      bcast_alu(4'(t), 32'hAA);
      cycle();
      chk("t5_no_dispatch", rs_ready, 0);
    end

    // Age ordering: A in entry 2, B later in entry 0, woken together.
    iss(ALU_ADD, 0, 0, 11, 1, 0, 0, 0);
    iss(ALU_ADD, 0, 0, 12, 1, 0, 0, 1);
    iss(ALU_SUB, 0, 0, 10, 1, 0, 0, 2);
    bcast_alu(11, 1);
    cycle();
    chk("t6_x0", rs_id, 0);
    bcast_alu(12, 2);
    iss(ALU_XOR, 0, 0, 10, 1, 0, 0, 5);
    chk("t6_x1", rs_id, 1);
    bcast_alu(10, 3);
    cycle();
`ifdef RS_OLDEST_FIRST_EN
    chk("t6_first",  rs_id, 2);
    cycle();
    chk("t6_second", rs_id, 5);
`else
    chk("t6_first",  rs_id, 5);
    cycle();
    chk("t6_second", rs_id, 2);
`endif
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rdy       = ($urandom_range(15) != 0);
      flush     = ($urandom_range(63) == 0);
      dec_valid = !m_full() && ($urandom_range(1) == 1);
      dec_op    = 4'($urandom_range(15));
      dec_val1  = $urandom; dec_val2 = $urandom;
      dec_has1  = $urandom_range(1) == 1; dec_has2 = $urandom_range(1) == 1;
      dec_q1    = 4'($urandom_range(15)); dec_q2 = 4'($urandom_range(15));
      dec_id    = 4'($urandom_range(15));
      alu_ready = $urandom_range(1) == 1; alu_id = 4'($urandom_range(15)); alu_res = $urandom;
      lsb_ready = $urandom_range(1) == 1; lsb_id = 4'($urandom_range(15)); lsb_res = $urandom;
      if (alu_ready && lsb_ready && alu_id == lsb_id) lsb_id = alu_id + 4'd1;
      cycle();
    end
    rdy = 1'b1; flush = 1'b0; dec_valid = 1'b0; alu_ready = 1'b0; lsb_ready = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
